// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and grant encodings for the memory port arbiter
//   IDLE/BUSY/DONE  : arbiter FSM states
//   GNT_*           : grant codes driven on the grant port
//   TIMER_W         : width of the watchdog counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_LD   = 2'b10;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - clear/enable watchdog counter with terminal-count flag
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count at zero (wins over enable)
//   enable     : advance the count by one this cycle
//   tc         : count has reached TIMEOUT-1
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign tc = (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (CPU / loader) arbiter onto one variable-latency memory
//   clk, reset                          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_ready/rdata : CPU port, req held until ready
//   ld_req/we/addr/wdata  -> ld_ready/rdata  : loader port, same handshake
//   mem_req/we/addr/wdata <- mem_ack/rdata   : memory side, req held until ack or abort
//   err                                 : pulses with ready when the access was aborted
//   grant                               : current owner (00 none, 01 CPU, 10 loader)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ready,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  output logic [1:0]    grant
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t    state, state_d;
  logic [3:0]    starve_cnt, starve_d;
  logic          mem_req_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, cpu_rdata_d, ld_rdata_d;
  logic          cpu_ready_d, ld_ready_d, err_d;
  logic [1:0]    grant_d;
  logic          timer_clear, timer_enable, timer_tc;
  logic          pick_ld;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tc     (timer_tc)
  );

  always_comb begin
    state_d      = state;
    starve_d     = starve_cnt;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    cpu_rdata_d  = cpu_rdata;
    ld_rdata_d   = ld_rdata;
    cpu_ready_d  = 1'b0;
    ld_ready_d   = 1'b0;
    err_d        = 1'b0;
    grant_d      = grant;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    // Loader goes through when alone, or when the CPU has beaten it STARVE_LIMIT times in a row.
    pick_ld      = ld_req && (!cpu_req || starve_cnt == STARVE_MAX);

    case (state)
      IDLE: begin
        if (cpu_req || ld_req) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          timer_clear = 1'b1;
          grant_d     = pick_ld ? GNT_LD   : GNT_CPU;
          mem_we_d    = pick_ld ? ld_we    : cpu_we;
          mem_addr_d  = pick_ld ? ld_addr  : cpu_addr;
          mem_wdata_d = pick_ld ? ld_wdata : cpu_wdata;
        end
        // Only a CPU win over a waiting loader counts towards starvation.
        if (!ld_req || pick_ld) begin
          starve_d = '0;
        end else if (starve_cnt != STARVE_MAX) begin
          starve_d = starve_cnt + 4'd1;
        end
      end

      BUSY: begin
        timer_enable = 1'b1;
        // An ack on the terminal cycle still counts as a normal completion.
        if (mem_ack || timer_tc) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = !mem_ack;
          if (grant == GNT_CPU) begin
            cpu_ready_d = 1'b1;
            if (!mem_we) cpu_rdata_d = mem_ack ? mem_rdata : '0;
          end else if (grant == GNT_LD) begin
            ld_ready_d = 1'b1;
            if (!mem_we) ld_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end

      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
      cpu_ready  <= 1'b0;
      ld_ready   <= 1'b0;
      err        <= 1'b0;
      grant      <= GNT_NONE;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_rdata  <= cpu_rdata_d;
      ld_rdata   <= ld_rdata_d;
      cpu_ready  <= cpu_ready_d;
      ld_ready   <= ld_ready_d;
      err        <= err_d;
      grant      <= grant_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int SL = 4;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ld_req, ld_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata, mem_rdata;
  logic        cpu_ready, ld_ready, mem_req, mem_we, err;
  logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ready  (ld_ready),
    .ld_rdata  (ld_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err),
    .grant     (grant)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: where the current access stands, who owns it, what it carries.
  int          m_phase  = 0;   // 0 waiting for a request, 1 memory access open, 2 completion cycle
  int          m_own    = 0;   // 1 CPU, 2 loader
  int          m_age    = 0;   // memory-access cycles elapsed
  int          m_starve = 0;
  logic        m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_cpu_rdata = '0, m_ld_rdata = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Applies the rules to the inputs that were present at the edge just taken.
  task automatic model_edge();
    bit take_ld;
    if (reset) begin
      m_phase = 0; m_own = 0; m_age = 0; m_starve = 0;
      m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
      m_cpu_rdata = '0; m_ld_rdata = '0;
      return;
    end
    if (m_phase == 0) begin
      take_ld = ld_req && (!cpu_req || m_starve == SL);
      if (cpu_req || ld_req) begin
        m_own   = take_ld ? 2 : 1;
        m_we    = take_ld ? ld_we : cpu_we;
        m_addr  = take_ld ? ld_addr : cpu_addr;
        m_wdata = take_ld ? ld_wdata : cpu_wdata;
        m_age   = 0;
        m_phase = 1;
      end
      if (!ld_req || take_ld) m_starve = 0;
      else if (m_starve < SL) m_starve = m_starve + 1;
    end else if (m_phase == 1) begin
      m_age++;
      if (mem_ack || m_age == TO) begin
        m_err   = !mem_ack;
        m_phase = 2;
        if (!m_we) begin
          if (m_own == 1) m_cpu_rdata = mem_ack ? mem_rdata : 32'h0;
          else            m_ld_rdata  = mem_ack ? mem_rdata : 32'h0;
        end
      end
    end else begin
      m_phase = 0;
      m_err   = 1'b0;
    end
  endtask

  task automatic compare();
    logic [1:0] eg;
    eg = (m_phase != 0) ? 2'(m_own) : 2'd0;
    chk("mem_req",   64'(mem_req),   64'(m_phase == 1));
    chk("grant",     64'(grant),     64'(eg));
    chk("cpu_ready", 64'(cpu_ready), 64'(m_phase == 2 && m_own == 1));
    chk("ld_ready",  64'(ld_ready),  64'(m_phase == 2 && m_own == 2));
    chk("err",       64'(err),       64'(m_phase == 2 && m_err));
    chk("mem_we",    64'(mem_we),    64'(m_we));
    chk("mem_addr",  64'(mem_addr),  64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(m_cpu_rdata));
    chk("ld_rdata",  64'(ld_rdata),  64'(m_ld_rdata));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    model_edge();
    compare();
  endtask

  initial begin
    int n, got, ack_pct;
    logic [1:0] prev;
    logic [1:0] seq [6];
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; mem_ack = 0; mem_rdata = '0;
    step(); step();
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    reset = 1'b0;
    step();

    // CPU read alone, memory acks two cycles after mem_req
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    step();
    chk("t1_mem_req", 64'(mem_req), 64'(1));
    chk("t1_mem_addr", 64'(mem_addr), 64'(32'h40));
    chk("t1_mem_we", 64'(mem_we), 64'(0));
    chk("t1_grant", 64'(grant), 64'(2'b01));
    step(); step();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0; cpu_req = 0;
    chk("t1_cpu_ready", 64'(cpu_ready), 64'(1));
    chk("t1_cpu_rdata", 64'(cpu_rdata), 64'(32'hDEADBEEF));
    chk("t1_ld_ready", 64'(ld_ready), 64'(0));
    step();
    chk("t1_ready_gone", 64'(cpu_ready), 64'(0));
    chk("t1_grant_end", 64'(grant), 64'(0));

    // Loader write alone, ack in the first memory cycle
    ld_req = 1; ld_we = 1; ld_addr = 32'h100; ld_wdata = 32'h12345678;
    step();
    chk("t2_mem_we", 64'(mem_we), 64'(1));
    chk("t2_mem_wdata", 64'(mem_wdata), 64'(32'h12345678));
    chk("t2_grant", 64'(grant), 64'(2'b10));
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 0; ld_req = 0;
    chk("t2_ld_ready", 64'(ld_ready), 64'(1));
    chk("t2_ld_rdata", 64'(ld_rdata), 64'(0));
    step(); step();

    // Starvation: both ports request back to back with immediate acks
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200; ld_req = 1; ld_we = 0; ld_addr = 32'h300;
    mem_ack = 1; mem_rdata = 32'h5555AAAA;
    n = 0; prev = grant;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant != 2'b00 && prev == 2'b00 && n < 6) begin
        seq[n] = grant;
        if (n == 3) chk("t3_model_starve_sat", 64'(m_starve), 64'(4));
        if (n == 4) chk("t3_model_starve_clr", 64'(m_starve), 64'(0));
        n++;
      end
      prev = grant;
    end
    chk("t3_grants", 64'(n), 64'(6));
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
    cpu_req = 0; ld_req = 0;
    step(); step(); step();
    mem_ack = 0;
    step();

    // Timeout: memory never answers
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
    n = 0; got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (mem_req) n++;
      if (cpu_ready) begin
        got = 1;
        chk("t4_err", 64'(err), 64'(1));
        chk("t4_cpu_rdata", 64'(cpu_rdata), 64'(0));
        cpu_req = 0;
      end
    end
    chk("t4_ready_seen", 64'(got), 64'(1));
    chk("t4_req_cycles", 64'(n), 64'(15));
    mem_ack = 1; mem_rdata = 32'h77777777;
    step();
    mem_ack = 0;
    step();
    chk("t4_late_ready", 64'(cpu_ready), 64'(0));
    chk("t4_late_rdata", 64'(cpu_rdata), 64'(0));

    // Ack on the final memory cycle beats the watchdog
    cpu_req = 1; cpu_addr = 32'hC0;
    step();
    for (int i = 0; i < 14; i++) step();
    chk("t5_still_busy", 64'(mem_req), 64'(1));
    mem_ack = 1; mem_rdata = 32'hA5A50F0F;
    step();
    mem_ack = 0; cpu_req = 0;
    chk("t5_ready", 64'(cpu_ready), 64'(1));
    chk("t5_err", 64'(err), 64'(0));
    chk("t5_rdata", 64'(cpu_rdata), 64'(32'hA5A50F0F));
    step();

    // Reset in the middle of an access
    cpu_req = 1; cpu_addr = 32'h44;
    step(); step();
    chk("t6_busy", 64'(mem_req), 64'(1));
    reset = 1; cpu_req = 0;
    step();
    reset = 0;
    chk("t6_mem_req", 64'(mem_req), 64'(0));
    chk("t6_grant", 64'(grant), 64'(0));
    chk("t6_rdata", 64'(cpu_rdata), 64'(0));
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("t6_no_ready", 64'(cpu_ready), 64'(0));
    chk("t6_no_err", 64'(err), 64'(0));
    step();

    // Random traffic against the reference
    ack_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) ack_pct = (c / 500 % 3 == 0) ? 60 : (c / 500 % 3 == 1) ? 25 : 6;
      if (!cpu_req || (m_phase == 2 && m_own == 1)) begin
        cpu_req = ($urandom_range(0, 9) < 4);
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom(); cpu_wdata = $urandom();
      end
      if (!ld_req || (m_phase == 2 && m_own == 2)) begin
        ld_req = ($urandom_range(0, 9) < 4);
        ld_we = 1'($urandom_range(0, 1)); ld_addr = $urandom(); ld_wdata = $urandom();
      end
      reset = ($urandom_range(0, 299) == 0);
      mem_ack = ($urandom_range(0, 99) < ack_pct);
      mem_rdata = $urandom();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
